// File: rtl/sram_array_ctrl_if.sv
// Request/response channel between a pipeline client and sram_array_ctrl.
//
// Handshake rule for both channels: a beat transfers on a rising clock edge
// where valid && ready are both high. The sender holds its payload stable
// while valid is high and ready is low. req_ready never depends on
// req_valid or req_wen; it may depend on resp_ready in the same cycle.
//
// Signals:
//   req_valid/req_ready          request handshake
//   req_wen                      1 = write, 0 = read
//   req_addr/req_wdata/req_wmask request payload (mask bit i covers data[2i+1:2i])
//   resp_valid/resp_ready        response handshake
//   resp_data                    read data, returned in request order
interface sram_array_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    // Client side
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    // Controller side
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_array_ctrl.sv
// Requester-side controller for a 512x16 dual-port SRAM macro with a 1-cycle
// read and a 2-bit-granular write mask.
//
// After reset the controller sweeps every entry to zero (INIT), then serves
// one read or write per cycle from the request channel (RUN). Read data is
// captured into a small FIFO so a stalled consumer never loses a response.
//
// Ports:
//   clock      in   single clock for the block and the SRAM
//   reset      in   asynchronous, active-low reset
//   bus        slave modport of sram_array_ctrl_if (request/response channels)
//   init_done  out  1 from the first cycle after the clear sweep
//   dbg_state  out  current FSM state (0 = INIT, 1 = RUN)
//   W0_*       out  SRAM write port (addr, en, data, mask)
//   R0_*       out/in SRAM read port (addr, en out; data in, valid the cycle after R0_en)
module sram_array_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int MASK_W     = 8,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    sram_array_ctrl_if.slave  bus,
    output logic              init_done,
    output logic              dbg_state,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [DATA_W-1:0] W0_data,
    output logic [MASK_W-1:0] W0_mask,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

    logic              ready;
    logic              pop;
    logic              push;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_init;
    logic [CNT_W:0]    occ;

    // Occupancy seen by a new request: stored entries plus the read already
    // in flight, minus the entry leaving this cycle. A pop implies count >= 1,
    // so the subtraction never underflows.
    assign pop    = bus.resp_valid && bus.resp_ready;
    assign push   = inflight;
    assign occ    = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign ready  = (state == RUN) && (occ < (CNT_W+1)'(RESP_DEPTH));
    assign wr_acc = bus.req_valid && ready && bus.req_wen;
    assign rd_acc = bus.req_valid && ready && !bus.req_wen;

    // The sweep write is gated by reset so the SRAM port reads idle while
    // reset is held, even though the state register already sits in INIT.
    assign in_init = (state == INIT) && reset;

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (count != '0);
    assign bus.resp_data  = bus.resp_valid ? fifo_mem[rptr] : '0;
    assign dbg_state      = state;

    always_comb begin
        W0_en   = 1'b0;
        W0_addr = '0;
        W0_data = '0;
        W0_mask = '0;
        R0_en   = 1'b0;
        R0_addr = '0;
        if (in_init) begin
            W0_en   = 1'b1;
            W0_addr = cnt;
            W0_mask = '1;
        end else if (wr_acc) begin
            W0_en   = 1'b1;
            W0_addr = bus.req_addr;
            W0_data = bus.req_wdata;
            W0_mask = bus.req_wmask;
        end
        if (rd_acc) begin
            R0_en   = 1'b1;
            R0_addr = bus.req_addr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            inflight  <= 1'b0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: state <= INIT;
            endcase

            // R0_data is valid exactly one cycle after the read accept; the
            // credit rule guarantees there is room for it.
            inflight <= rd_acc;
            if (push) begin
                wptr <= (wptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wptr] <= R0_data;
        end
    end
endmodule
